// File: rtl/except_ctrl_pkg.sv
// Shared definitions for the MEM-stage exception controller:
// cause codes, flag bit positions, FSM encoding and the selection bundle.
package except_ctrl_pkg;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TR   = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    localparam int FLG_ADEL_F = 0;
    localparam int FLG_RI     = 1;
    localparam int FLG_OV     = 2;
    localparam int FLG_TRAP   = 3;
    localparam int FLG_SYS    = 4;
    localparam int FLG_BREAK  = 5;
    localparam int FLG_ADEL_L = 6;
    localparam int FLG_ADES   = 7;
    localparam int FLG_ERET   = 8;
    localparam int NFLAGS     = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic        hit;
        logic        eret;
        logic [31:0] code;
        logic [31:0] bad_vaddr;
    } exc_sel_t;

endpackage

// File: rtl/except_ctrl_prio_enc.sv
// Fixed-priority cause selection for the MEM-stage instruction.
// Interrupts win over every synchronous cause, including eret.
module exc_prio_enc
    import except_ctrl_pkg::*;
(
    input  logic              i_int_pend,
    input  logic [NFLAGS-1:0] i_flags,
    input  logic [31:0]       i_pc,
    input  logic [31:0]       i_mem_addr,
    output exc_sel_t          o_sel
);

    // pick the single highest-priority pending cause
    always_comb begin
        o_sel = '0;
        if (i_int_pend) begin
            o_sel.hit  = 1'b1;
            o_sel.code = EXC_INT;
        end else if (i_flags[FLG_ADEL_F]) begin
            o_sel.hit       = 1'b1;
            o_sel.code      = EXC_ADEL;
            o_sel.bad_vaddr = i_pc;
        end else if (i_flags[FLG_RI]) begin
            o_sel.hit  = 1'b1;
            o_sel.code = EXC_RI;
        end else if (i_flags[FLG_OV]) begin
            o_sel.hit  = 1'b1;
            o_sel.code = EXC_OV;
        end else if (i_flags[FLG_TRAP]) begin
            o_sel.hit  = 1'b1;
            o_sel.code = EXC_TR;
        end else if (i_flags[FLG_SYS]) begin
            o_sel.hit  = 1'b1;
            o_sel.code = EXC_SYS;
        end else if (i_flags[FLG_BREAK]) begin
            o_sel.hit  = 1'b1;
            o_sel.code = EXC_BP;
        end else if (i_flags[FLG_ADEL_L]) begin
            o_sel.hit       = 1'b1;
            o_sel.code      = EXC_ADEL;
            o_sel.bad_vaddr = i_mem_addr;
        end else if (i_flags[FLG_ADES]) begin
            o_sel.hit       = 1'b1;
            o_sel.code      = EXC_ADES;
            o_sel.bad_vaddr = i_mem_addr;
        end else if (i_flags[FLG_ERET]) begin
            o_sel.hit  = 1'b1;
            o_sel.eret = 1'b1;
            o_sel.code = EXC_ERET;
        end
    end

endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception controller: picks one cause, reports it to CP0,
// pulses a flush with the redirect target, then drains the pipeline.
module except_ctrl
    import except_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic [8:0]  exc_flags_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic [5:0]  int_hw_i,
    input  logic        timer_int_i,
    output logic [5:0]  int_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] pc_o,
    output logic [31:0] bad_vaddr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    localparam logic [15:0] DRAIN_LOAD =
        (DRAIN_CYCLES > 0) ? 16'(DRAIN_CYCLES - 1) : 16'd0;
    localparam logic HAS_DRAIN = (DRAIN_CYCLES > 0);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic [5:0]  r_sync1;
    logic [5:0]  r_sync2;
    logic [31:0] r_exctype;
    logic [31:0] r_pc;
    logic [31:0] r_bad;
    logic        r_ds;
    logic        r_eret;
    logic        w_int_pend;
    logic        w_accept;
    exc_sel_t    w_sel;
    logic        w_unused;

    // interrupts only when enabled (IE=1) and not already in exception level
    assign w_int_pend = status_i[0] & ~status_i[1]
                      & (|(cause_i[15:8] & status_i[15:8]));

    assign w_unused = ^{stall[5], stall[3:0], status_i[31:16],
                        status_i[7:2], cause_i[31:16], cause_i[7:0]};

    exc_prio_enc u_enc (
        .i_int_pend (w_int_pend),
        .i_flags    (exc_flags_i),
        .i_pc       (pc_i),
        .i_mem_addr (mem_addr_i),
        .o_sel      (w_sel)
    );

    assign w_accept = (r_state == ST_IDLE) & valid_i & ~stall[4] & w_sel.hit;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // FSM next state: IDLE -> COMMIT -> DRAIN -> IDLE
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_accept) w_next = ST_COMMIT;
            ST_COMMIT: w_next = HAS_DRAIN ? ST_DRAIN : ST_IDLE;
            ST_DRAIN:  if (r_cnt == 16'd0) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // drain counter, loaded on leaving COMMIT and counted down in DRAIN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_COMMIT) begin
            r_cnt <= DRAIN_LOAD;
        end else if (r_state == ST_DRAIN && r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
        end
    end

    // capture the winning cause; code is live only for the COMMIT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exctype <= '0;
            r_pc      <= '0;
            r_bad     <= '0;
            r_ds      <= 1'b0;
            r_eret    <= 1'b0;
        end else begin
            r_exctype <= w_accept ? w_sel.code : 32'd0;
            if (w_accept) begin
                r_pc   <= pc_i;
                r_bad  <= w_sel.bad_vaddr;
                r_ds   <= is_in_delayslot_i;
                r_eret <= w_sel.eret;
            end
        end
    end

    // two-flop synchronizer for the asynchronous interrupt pins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= int_hw_i;
            r_sync2 <= r_sync1;
        end
    end

    assign int_o             = {r_sync2[5] | timer_int_i, r_sync2[4:0]};
    assign pc_o              = r_pc;
    assign bad_vaddr_o       = r_bad;
    assign is_in_delayslot_o = r_ds;

    // FSM outputs: flush and redirect exist only during COMMIT
    always_comb begin
        flush_o      = 1'b0;
        new_pc_o     = '0;
        excepttype_o = '0;
        if (r_state == ST_COMMIT) begin
            flush_o      = 1'b1;
            new_pc_o     = r_eret ? epc_i : EXC_VECTOR;
            excepttype_o = r_exctype;
        end
    end

endmodule

// File: doc/except_ctrl.md
EXCEPT_CTRL -- requirements
Module: except_ctrl

Interface
REQ-001 Parameter: EXC_VECTOR, default 32'hBFC00380, exception entry address.
REQ-002 Parameter: DRAIN_CYCLES, default 2, cycles incoming instructions are ignored after a flush.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 stall  in  6  pipeline stall bus; bit4=1 means the MEM stage is held.
REQ-006 valid_i  in  1  MEM-stage instruction valid.
REQ-007 pc_i  in  32  MEM-stage instruction PC.
REQ-008 is_in_delayslot_i  in  1  MEM instruction sits in a branch delay slot.
REQ-009 exc_flags_i  in  9  per-cause flags; bit order: [0] adel_fetch, [1] ri, [2] ov, [3] trap, [4] syscall, [5] break, [6] adel_ls, [7] ades, [8] eret.
REQ-010 mem_addr_i  in  32  load/store effective address.
REQ-011 status_i, cause_i, epc_i  in  32 each  current CP0 Status/Cause/EPC.
REQ-012 int_hw_i  in  6  asynchronous hardware interrupt lines.
REQ-013 timer_int_i  in  1  CP0 timer interrupt.
REQ-014 int_o  out  6  synchronized interrupt lines to CP0 Cause[15:10].
REQ-015 excepttype_o  out  32  registered exception code to CP0.
REQ-016 pc_o, bad_vaddr_o  out  32 each  registered PC and bad address to CP0.
REQ-017 is_in_delayslot_o  out  1  registered delay-slot flag to CP0.
REQ-018 flush_o  out  1  one-cycle pipeline flush pulse.
REQ-019 new_pc_o  out  32  redirect target, valid while flush_o=1.

Function
REQ-020 int_hw_i SHALL pass through a 2-flop synchronizer; int_o = {sync[5] | timer_int_i, sync[4:0]}.
REQ-021 Interrupt pending SHALL be: status_i[0]=1, status_i[1]=0, and (cause_i[15:8] & status_i[15:8]) != 0.
REQ-022 An event SHALL be accepted only in IDLE, with valid_i=1 and stall[4]=0.
REQ-023 Priority, highest first, SHALL be: interrupt (0x01), adel_fetch (0x04), ri (0x0a), ov (0x0c), trap (0x0d), syscall (0x08), break (0x09), adel_ls (0x04), ades (0x05), eret (0x0e).
REQ-024 bad_vaddr_o SHALL be pc_i for adel_fetch, mem_addr_i for adel_ls/ades, and 0 otherwise.
REQ-025 On acceptance, excepttype_o, pc_o, bad_vaddr_o and is_in_delayslot_o SHALL register the winning cause, and FSM IDLE->COMMIT.
REQ-026 COMMIT SHALL last exactly 1 cycle:
- flush_o=1;
- new_pc_o = epc_i for eret, EXC_VECTOR otherwise;
- then COMMIT->DRAIN, loading the counter with DRAIN_CYCLES-1.
REQ-027 Outside COMMIT, excepttype_o SHALL be 0, flush_o SHALL be 0, and new_pc_o SHALL be 0.
REQ-028 DRAIN SHALL ignore all inputs except int_hw_i, decrement the counter each cycle, and go DRAIN->IDLE when the counter reaches 0.
REQ-029 Latency SHALL be: event sampled at edge N, excepttype_o/flush_o high in cycle N+1, CP0 commits at edge N+2.
REQ-030 When stall[4]=1 in IDLE, the block SHALL not accept the event and SHALL stay in IDLE; the event is re-evaluated when the stall releases.
REQ-031 Several flags set together SHALL yield only the highest-priority code; exactly one exception commits.
REQ-032 Interrupt plus eret together SHALL report an interrupt; this requires EXL=0 per REQ-021.
REQ-033 exc_flags_i=0 with no interrupt pending SHALL cause no state change.

Reset
REQ-034 On rst, the FSM SHALL go to IDLE, the drain counter and synchronizer SHALL clear, and all outputs SHALL be 0.
REQ-035 rst asserted in COMMIT or DRAIN SHALL abort immediately, with no flush in the following cycle.

Structure
REQ-036 Exception codes (0x01..0x0e), EXC_VECTOR, exc_flags_i bit indices and FSM state encodings SHALL live in the shared defines header.
REQ-037 The priority encoder SHALL be one combinational sub-module, exc_prio_enc.

Verification
REQ-038 valid_i=1, exc_flags_i[4]=1, pc_i=0x8000_0100 -> next cycle excepttype_o=0x08, pc_o=0x8000_0100, flush_o=1, new_pc_o=0xBFC0_0380.
REQ-039 exc_flags_i[7]=1, mem_addr_i=0x8000_0003 -> excepttype_o=0x05, bad_vaddr_o=0x8000_0003.
REQ-040 status_i=0x0000_0401, cause_i=0x0000_0400, valid_i=1, exc_flags_i[2]=1 -> excepttype_o=0x01; ov suppressed.
REQ-041 exc_flags_i[8]=1, epc_i=0x8000_0200 -> excepttype_o=0x0e, new_pc_o=0x8000_0200; syscall presented during the following 2 DRAIN cycles is ignored.
REQ-042 stall[4]=1 with exc_flags_i[5]=1 for 3 cycles, then release -> flush_o pulses once, 1 cycle after release.
REQ-043 rst asserted during COMMIT -> flush_o=0 and all outputs 0 on the next cycle.
